// File: rtl/twiddle_convert8_pkg.sv
// Shared FFT types and helpers: quadrant enum, twiddle control word,
// full-scale constants and saturating negation.
package twiddle_convert8_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  typedef struct packed {
    logic  valid;
    quad_e q;
    logic  swap;
    logic  zero;
  } ctl_t;

  localparam int unsigned CTL_W = $bits(ctl_t);
  // Working width for sign-extended component arithmetic; WIDTH must stay below it.
  localparam int unsigned SAT_W = 32;

  function automatic logic signed [SAT_W-1:0] max_pos(input int unsigned w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] max_neg(input int unsigned w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  // -x in w-bit two's complement, clamping the single overflow case.
  function automatic logic signed [SAT_W-1:0] sat_neg(input logic signed [SAT_W-1:0] x,
                                                      input int unsigned w);
    if (x == max_neg(w)) return max_pos(w);
    return -x;
  endfunction

endpackage

// File: rtl/tc8_delay.sv
// Fixed-depth shift register with async active-low clear, no stall.
module tc8_delay #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/twiddle_convert8.sv
// Twiddle symmetry converter: folds index k onto an eighth/quarter-wave
// table and rebuilds the full-circle twiddle from the returned entry.
module twiddle_convert8
  import twiddle_convert8_pkg::*;
#(
  parameter int unsigned LOG_N  = 6,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned OCTANT = 1,
  parameter int unsigned TB_LAT = 1,
  parameter int unsigned OUT_FF = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    di_en,
  input  logic [LOG_N-1:0]        tw_addr,
  output logic [LOG_N-3:0]        tb_addr,
  input  logic signed [WIDTH-1:0] tb_re,
  input  logic signed [WIDTH-1:0] tb_im,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] tc_re,
  output logic signed [WIDTH-1:0] tc_im,
  output logic                    tc_one
);

  localparam int unsigned M_W     = LOG_N - 2;
  localparam int unsigned QUARTER = 1 << M_W;
  localparam int unsigned EIGHTH  = 1 << (LOG_N - 3);

  logic [M_W-1:0]          m;
  logic                    swap_c;
  ctl_t                    ctl_in;
  logic [CTL_W-1:0]        ctl_dly_bits;
  ctl_t                    ctl_dly;
  logic signed [SAT_W-1:0] r0, i0, r1, i1, rr, ri;
  logic signed [WIDTH-1:0] conv_re_c, conv_im_c;
  logic                    conv_one_c;

  // Fold the in-quadrant offset onto the stored table range.
  always_comb begin
    m       = tw_addr[M_W-1:0];
    swap_c  = (OCTANT != 0) && (32'(m) > EIGHTH);
    tb_addr = swap_c ? M_W'(QUARTER - 32'(m)) : m;
    ctl_in  = '{valid: di_en,
                q:     quad_e'(tw_addr[LOG_N-1 -: 2]),
                swap:  swap_c,
                zero:  (m == '0)};
  end

  tc8_delay #(.W(CTL_W), .DEPTH(TB_LAT)) u_ctl_dly (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (ctl_in),
    .q       (ctl_dly_bits)
  );

  assign ctl_dly = ctl_t'(ctl_dly_bits);

  // Unfold the octant swap, rotate by (-j)^q, then patch the exact axis points.
  always_comb begin
    r0         = {{(SAT_W-WIDTH){tb_re[WIDTH-1]}}, tb_re};
    i0         = {{(SAT_W-WIDTH){tb_im[WIDTH-1]}}, tb_im};
    r1         = r0;
    i1         = i0;
    rr         = '0;
    ri         = '0;
    conv_one_c = 1'b0;
    if (ctl_dly.swap) begin
      r1 = sat_neg(i0, WIDTH);
      i1 = sat_neg(r0, WIDTH);
    end
    case (ctl_dly.q)
      Q0: begin rr = r1;                 ri = i1;                 end
      Q1: begin rr = i1;                 ri = sat_neg(r1, WIDTH); end
      Q2: begin rr = sat_neg(r1, WIDTH); ri = sat_neg(i1, WIDTH); end
      Q3: begin rr = sat_neg(i1, WIDTH); ri = r1;                 end
    endcase
    if (ctl_dly.zero) begin
      case (ctl_dly.q)
        Q0: begin rr = '0;             ri = '0;             conv_one_c = 1'b1; end
        Q1: begin rr = '0;             ri = max_neg(WIDTH); end
        Q2: begin rr = max_neg(WIDTH); ri = '0;             end
        Q3: begin rr = '0;             ri = max_pos(WIDTH); end
      endcase
    end
    conv_re_c = WIDTH'(rr);
    conv_im_c = WIDTH'(ri);
  end

  if (OUT_FF != 0) begin : g_out_ff
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        do_en  <= 1'b0;
        tc_re  <= '0;
        tc_im  <= '0;
        tc_one <= 1'b0;
      end else begin
        do_en <= ctl_dly.valid;
        if (ctl_dly.valid) begin
          tc_re  <= conv_re_c;
          tc_im  <= conv_im_c;
          tc_one <= conv_one_c;
        end
      end
    end
  end else begin : g_out_comb
    // Zeroed while invalid so reset shows all-zero outputs.
    always_comb begin
      do_en  = ctl_dly.valid;
      tc_re  = ctl_dly.valid ? conv_re_c : '0;
      tc_im  = ctl_dly.valid ? conv_im_c : '0;
      tc_one = ctl_dly.valid & conv_one_c;
    end
  end

endmodule

// File: tb/tb_twiddle_convert8.sv
// Directed bench for twiddle_convert8: registered 1-cycle-ROM instance (a)
// and combinational-output 3-cycle-ROM instance (b), both N=64, eighth-wave.
module tb_twiddle_convert8;

  localparam int LAT_A = 2;
  localparam real PI = 3.14159265358979;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic              di_en_a, do_en_a, tc_one_a;
  logic [5:0]        tw_addr_a;
  logic [3:0]        tb_addr_a;
  logic signed [15:0] tb_re_a, tb_im_a, tc_re_a, tc_im_a;
  logic              di_en_b, do_en_b, tc_one_b;
  logic [5:0]        tw_addr_b;
  logic [3:0]        tb_addr_b;
  logic signed [15:0] tb_re_b, tb_im_b, tc_re_b, tc_im_b;

  twiddle_convert8 #(.LOG_N(6), .WIDTH(16), .OCTANT(1), .TB_LAT(1), .OUT_FF(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .di_en(di_en_a), .tw_addr(tw_addr_a),
    .tb_addr(tb_addr_a), .tb_re(tb_re_a), .tb_im(tb_im_a), .do_en(do_en_a),
    .tc_re(tc_re_a), .tc_im(tc_im_a), .tc_one(tc_one_a));

  twiddle_convert8 #(.LOG_N(6), .WIDTH(16), .OCTANT(1), .TB_LAT(3), .OUT_FF(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .di_en(di_en_b), .tw_addr(tw_addr_b),
    .tb_addr(tb_addr_b), .tb_re(tb_re_b), .tb_im(tb_im_b), .do_en(do_en_b),
    .tc_re(tc_re_b), .tc_im(tc_im_b), .tc_one(tc_one_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit force_im = 1'b0;
  logic signed [15:0] re_tab [16];
  logic signed [15:0] im_tab [16];
  logic signed [15:0] br [3];
  logic signed [15:0] bi [3];

  always @(posedge clock) cyc <= cyc + 1;

  // ROM models: one-cycle for a (with a forced -full-scale entry), three-cycle for b.
  always @(posedge clock) begin
    tb_re_a <= re_tab[tb_addr_a];
    tb_im_a <= (force_im && tb_addr_a == 4'd7) ? 16'sh8000 : im_tab[tb_addr_a];
    br[0] <= re_tab[tb_addr_b];
    bi[0] <= im_tab[tb_addr_b];
    br[1] <= br[0];
    bi[1] <= bi[0];
    br[2] <= br[1];
    bi[2] <= bi[1];
  end
  assign tb_re_b = br[2];
  assign tb_im_b = bi[2];

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction
  function automatic int ideal_re(input int k);
    return rnd($cos(2.0 * PI * k / 64.0) * 32767.0);
  endfunction
  function automatic int ideal_im(input int k);
    return rnd(-$sin(2.0 * PI * k / 64.0) * 32767.0);
  endfunction

  task automatic chk(input string name, input int act, input int req, input int tol);
    int d;
    total++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int re;
    int im;
    int one;
    int tol;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard for instance a: every do_en pulse must match the next expectation.
  always @(negedge clock) begin
    exp_t e;
    if (do_en_a) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_do_en: got do_en=1 want 0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("a_latency", cyc, e.cyc, 0);
        chk("a_re", tc_re_a, e.re, e.tol);
        chk("a_im", tc_im_a, e.im, e.tol);
        chk("a_one", tc_one_a, e.one, 0);
      end
    end
  end

  task automatic drive_a(input bit en, input int k);
    @(posedge clock);
    #1;
    di_en_a   = en;
    tw_addr_a = 6'(k);
  endtask

  task automatic push_a(input int re, input int im, input int one, input int tol);
    sbq.push_back('{cyc + LAT_A, re, im, one, tol});
  endtask

  typedef struct {
    int k;
    int addr;
    int re;
    int im;
    int one;
  } vec_t;

  int quad_addr [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
  int kb [5]  = '{5, 0, 33, 58, 0};
  int pat [5] = '{1, 0, 1, 1, 0};
  int rk [10] = '{3, 17, 40, 62, 9, 1, 20, 33, 50, 63};

  initial begin
    vec_t vt [6];
    vt[0] = '{0,  0, 0,      0,      1};
    vt[1] = '{16, 0, 0,      -32768, 0};
    vt[2] = '{32, 0, -32768, 0,      0};
    vt[3] = '{48, 0, 0,      32767,  0};
    vt[4] = '{8,  8, 23170,  -23170, 0};
    vt[5] = '{24, 8, -23170, -23170, 0};

    for (int a = 0; a < 16; a++) begin
      re_tab[a] = (a <= 8) ? 16'(ideal_re(a)) : 16'sd0;
      im_tab[a] = (a <= 8) ? 16'(ideal_im(a)) : 16'sd0;
    end
    reset_n = 1'b0;
    di_en_a = 1'b0; tw_addr_a = '0;
    di_en_b = 1'b0; tw_addr_b = '0;

    #1;
    chk("rst_do_en_a", do_en_a, 0, 0);
    chk("rst_re_a", tc_re_a, 0, 0);
    chk("rst_im_a", tc_im_a, 0, 0);
    chk("rst_one_a", tc_one_a, 0, 0);
    chk("rst_do_en_b", do_en_b, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Axis points and octant boundary, exact values.
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, vt[i].k);
      push_a(vt[i].re, vt[i].im, vt[i].one, 0);
      #1 chk("vec_addr", tb_addr_a, vt[i].addr, 0);
    end
    repeat (3) drive_a(1'b0, 0);

    // Full-circle back-to-back sweep against the ideal twiddle.
    for (int k = 0; k < 64; k++) begin
      drive_a(1'b1, k);
      if (k == 0) push_a(0, 0, 1, 0);
      else        push_a(ideal_re(k), ideal_im(k), 0, 1);
      #1 chk("sweep_addr", tb_addr_a, quad_addr[k % 16], 0);
    end
    repeat (3) drive_a(1'b0, 0);

    // Swap path fed a -full-scale imag entry must clamp, not wrap.
    force_im = 1'b1;
    drive_a(1'b1, 9);
    push_a(32767, -int'(re_tab[7]), 0, 0);
    drive_a(1'b0, 0);
    force_im = 1'b0;
    repeat (3) drive_a(1'b0, 0);

    // Gapped input on the 3-cycle, unregistered instance.
    for (int j = 0; j < 10; j++) begin
      @(posedge clock);
      #1;
      di_en_b   = (j < 5) ? pat[j][0] : 1'b0;
      tw_addr_b = (j < 5) ? 6'(kb[j]) : 6'd0;
      @(negedge clock);
      if (j >= 3 && j < 8) begin
        chk("b_do_en", do_en_b, pat[j-3], 0);
        if (pat[j-3] != 0) begin
          chk("b_re", tc_re_b, ideal_re(kb[j-3]), 1);
          chk("b_im", tc_im_b, ideal_im(kb[j-3]), 1);
          chk("b_one", tc_one_b, 0, 0);
        end
      end else begin
        chk("b_do_en_idle", do_en_b, 0, 0);
      end
    end

    // Reset mid-stream: indices 3 and 4 are in flight and must be dropped.
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, rk[i]);
      if (i < 3) push_a(ideal_re(rk[i]), ideal_im(rk[i]), 0, 1);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    di_en_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("mid_rst_do_en", do_en_a, 0, 0);
      chk("mid_rst_re", tc_re_a, 0, 0);
      chk("mid_rst_one", tc_one_a, 0, 0);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) drive_a(1'b0, 0);
    for (int i = 5; i < 10; i++) begin
      drive_a(1'b1, rk[i]);
      push_a(ideal_re(rk[i]), ideal_im(rk[i]), 0, 1);
    end
    repeat (5) drive_a(1'b0, 0);
    chk("a_pending_left", sbq.size(), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/twiddle_convert8.md
# twiddle_convert8

Twiddle-factor symmetry converter for the R2²SDF pipeline. It folds a full-circle twiddle index onto an eighth-wave (or quarter-wave) table, issues the folded table address, and realigns the returned table value with a delayed control pipeline. It then applies swap, negation and quadrant rotation and emits a valid-tagged twiddle to the stage multiplier. It sits between each butterfly stage's twiddle-index counter and its shared cos/sin ROM, cutting ROM depth to N/8+1 entries.

## Interface
- LOG_N, 6: twiddle index width, N = 2^LOG_N; legal range 4..16.
- WIDTH, 16: twiddle component width, signed two's complement, full scale ≈ 1.0.
- OCTANT, 1: 1 = eighth-wave table (entries 0..N/8); 0 = quarter-wave table (entries 0..N/4-1).
- TB_LAT, 1: table read latency in cycles; legal range 1..3.
- OUT_FF, 1: 1 = registered outputs; 0 = combinational from the conversion stage.
- clock  in  1  master clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- di_en  in  1  input index valid.
- tw_addr  in  LOG_N  twiddle index k, 0..N-1.
- tb_addr  out  LOG_N-2  folded table address, combinational from tw_addr.
- tb_re  in  WIDTH  table real value cos(2πa/N), valid TB_LAT cycles after tb_addr.
- tb_im  in  WIDTH  table imag value -sin(2πa/N), same timing as tb_re.
- do_en  out  1  output twiddle valid.
- tc_re  out  WIDTH  converted twiddle, real.
- tc_im  out  WIDTH  converted twiddle, imag.
- tc_one  out  1  twiddle is exactly 1+j0, so the multiplier is bypassed.

## Operation
- Decompose k: q = k[LOG_N-1:LOG_N-2] (quadrant); m = k[LOG_N-3:0].
- Fold:
  - OCTANT=1 and m > N/8: swap = 1, a = N/4 - m.
  - Otherwise: swap = 0, a = m.
- tb_addr = a. It is driven regardless of di_en; the table is read-only and has no side effects.
- Control word {valid, q, swap, zero = (m==0)} enters a TB_LAT-deep shift register clocked every cycle, with no stall.
- Conversion, on aligned (r,i) = (tb_re,tb_im):
  - Unfold: swap=1 gives (r,i) ← (-i,-r).
  - Rotate by (-j)^q:
    - q0: (r,i)
    - q1: (i,-r)
    - q2: (-r,-i)
    - q3: (-i,r)
  - zero=1 overrides the table value:
    - q0: (0,0) with tc_one=1
    - q1: (0,-2^(WIDTH-1))
    - q2: (-2^(WIDTH-1),0)
    - q3: (0,2^(WIDTH-1)-1)
  - tc_one=0 in every other case.
- Negation saturates: -(-2^(WIDTH-1)) = 2^(WIDTH-1)-1. No other width growth; output width equals WIDTH.
- do_en = delayed valid. When do_en=0, tc_re/tc_im/tc_one are held at their last values (OUT_FF=1) or are don't-care (OUT_FF=0).

## Timing
- Index presented with di_en at cycle t gives the twiddle at cycle t+TB_LAT+OUT_FF, with do_en high that cycle.
- Throughput is one index per cycle. Back-to-back and gapped di_en are both supported; output gaps mirror input gaps exactly.
- Reset (asserts asynchronously, releases synchronously to the design):
  - do_en=0, tc_re=0, tc_im=0, tc_one=0.
  - All control-pipeline valids are cleared.
- Reset mid-stream: all in-flight indices are dropped. No do_en pulse occurs for any index accepted before reset. The first do_en after release comes TB_LAT+OUT_FF cycles after the first post-reset di_en.
- OCTANT=1 boundary: m = N/8 gives a = N/8 with swap=0. The table must hold entry N/8.
- Wrap: k = N-1 followed by k = 0 needs no special handling; each index is independent.

## Structure
- The shared FFT package holds:
  - the quadrant enum (Q0..Q3),
  - the control-word struct {valid,q,swap,zero},
  - constants MAX_POS/MAX_NEG as functions of WIDTH,
  - a saturating-negate function.
- Sub-module tc8_delay: a parametrised TB_LAT-deep control shift register with async active-low clear. It is reused by the stage data-alignment logic.
- The conversion mux and the output register are in the top level.

## Test plan
- LOG_N=6, OCTANT=1, TB_LAT=1, OUT_FF=1, ideal ROM model:
  - k=0..63 back-to-back → tb_addr sequence 0..8,7..1 repeating per quadrant.
  - Each output matches round(cos, -sin of 2πk/64) within 1 LSB, do_en 2 cycles after di_en.
  - tc_one=1 only for k=0.
- k=16, 32, 48 → (0,-32768), (-32768,0), (0,32767) with tc_one=0.
- k=8 and k=24 (octant boundary) → tb_addr 8 both. Outputs are (23170,-23170) and (-23170,-23170).
- TB_LAT=3, OUT_FF=0, di_en pattern 1,0,1,1,0 → do_en pattern identical, shifted 3 cycles.
- Table entry forced to -32768 on a swap=1 index → saturated 32767 output, no wrap to -32768.
- Stream of 10 indices, reset_n pulsed low after the 5th → do_en stays 0 through reset. First post-reset di_en produces do_en after exactly TB_LAT+OUT_FF cycles.
